rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback stage and the multicycle multiply/divide unit (MDU).
- Holds a per-register busy scoreboard for MDU destinations, which decode uses for hazard detection.
- Guarantees the MDU is never starved by raising a one-cycle pipeline stall.
- Sits between the WB stage, the MDU and the register file's write port.

Parameters:
- DATA_WIDTH, 32, width of write data.
- STARVE_LIMIT, 4, cycles an MDU result may wait before the pipeline is stalled; must be >= 1.
- CNT_W, $clog2(STARVE_LIMIT+1), wait counter width; localparam.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wb_en  input  1  pipeline writeback request.
- wb_addr  input  5  pipeline destination register.
- wb_data  input  DATA_WIDTH  pipeline write data.
- mdu_valid  input  1  MDU result available.
- mdu_addr  input  5  MDU destination register.
- mdu_data  input  DATA_WIDTH  MDU result.
- mdu_ready  output  1  MDU result accepted this cycle.
- issue_valid  input  1  decode issuing an MDU op.
- issue_addr  input  5  destination of the issued MDU op.
- issue_ready  output  1  issue accepted (destination not already busy).
- rs_addr  input  5  decode hazard query 1.
- rt_addr  input  5  decode hazard query 2.
- rs_busy  output  1  rs has a pending MDU write.
- rt_busy  output  1  rt has a pending MDU write.
- stall_pipe  output  1  pipeline must freeze and re-present WB next cycle.
- rf_wr_en  output  1  register file write enable.
- rf_wr_addr  output  5  register file write address.
- rf_wr_data  output  DATA_WIDTH  register file write data.
- busy_vec  output  32  scoreboard contents, bit i = register i pending.

Behaviour:
- State: busy[31:0] and wait_cnt[CNT_W-1:0]. Asynchronous reset clears both.
- While rst_n=0, all outputs are 0, including mdu_ready, issue_ready, stall_pipe and rf_wr_en.
- Reset mid-transaction abandons the pending MDU result; the MDU must re-present it after reset.
- rf_wr_* are combinational within the cycle. The register file commits on the falling edge of that same cycle, so write latency is 0 cycles from grant.
- wb_claim = wb_en && wb_addr!=0. A WB write to $0 does not occupy the port.
- stall_pipe = (wait_cnt == STARVE_LIMIT), decoded from a register with no combinational input path.
- Grant priority:
  - stall_pipe=1: mdu_ready=1 and the MDU is granted. wb_* is ignored; the pipeline holds and re-presents it next cycle.
  - Else if wb_claim: WB is granted and mdu_ready=0.
  - Else: mdu_ready=1 and the MDU is granted when mdu_valid=1.
- A handshake occurs when mdu_valid && mdu_ready.
- rf_wr_en is 1 only when the granted source's address is nonzero. An MDU result for $0 still completes its handshake but writes nothing.
- With no grant: rf_wr_en=0, and rf_wr_addr/rf_wr_data carry WB values (don't-care).
- wait_cnt on each posedge:
  - Cleared on an MDU handshake or when mdu_valid=0.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - An MDU result therefore waits at most STARVE_LIMIT cycles.
- MDU contract: mdu_addr and mdu_data stay stable while mdu_valid is high and unaccepted.
- Scoreboard:
  - issue_ready = !busy[issue_addr] || issue_addr==0.
  - Issue handshake with issue_addr!=0 sets the busy bit at the next posedge. issue_addr==0 never sets busy.
  - MDU handshake clears busy[mdu_addr] at the next posedge.
  - Same register set and cleared in the same cycle: set wins.
  - A clear for a register that is not busy is a no-op.
- rs_busy = busy[rs_addr] and rt_busy = busy[rt_addr], read from registered state. Bit 0 is always 0.
- A register stays busy during its write cycle and clears the cycle after. This is conservative; there is no bypass.
- busy_vec mirrors busy directly.

Decomposition:
- Package rf_ctrl_pkg holds REG_ADDR_W=5, NUM_REGS=32 and ZERO_REG=5'd0.
- Sub-module rf_scoreboard holds the busy vector, the set/clear ports with set-wins priority, the two query ports and issue_ready.
- The arbiter and wait counter stay in the top level.

Test Plan:
- Idle, then mdu_valid=1, addr=5, data=32'hDEAD, wb_en=0 -> mdu_ready=1 and rf_wr_en=1/addr 5/data DEAD the same cycle; busy[5] clears the next cycle.
- wb_en=1, wb_addr=3, held continuously, with mdu_valid=1, addr=7:
  - Cycles 0-3: WB is granted and mdu_ready=0.
  - Cycle 4: stall_pipe=1, the MDU writes reg 7 and wait_cnt returns to 0.
  - Cycle 5: WB is granted again.
- Issue addr 9, then issue addr 9 again -> the first is accepted; the second sees issue_ready=0 while busy[9]=1. rs_addr=9 gives rs_busy=1.
- MDU handshake for reg 4 and issue to reg 4 in the same cycle -> busy[4]=1 afterwards. Issue to reg 0 -> busy_vec is unchanged.
- Writes to register 0:
  - wb_en=1, wb_addr=0 with mdu_valid=1 -> the MDU is granted.
  - mdu_addr=0 -> handshake completes with rf_wr_en=0.
- rst_n dropped asynchronously mid-wait with wait_cnt=2 and busy[5,9]=1 -> all outputs 0 immediately. After release, busy_vec=0 and wait_cnt=0.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control types: address width, register count and the hardwired zero register.
package rf_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Handshake bundle between the WB stage, the MDU, decode and the register file write port.
interface rf_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    import rf_ctrl_pkg::*;

    logic                  wb_en;
    reg_addr_t             wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  mdu_valid;
    reg_addr_t             mdu_addr;
    logic [DATA_WIDTH-1:0] mdu_data;
    logic                  mdu_ready;

    logic                  issue_valid;
    reg_addr_t             issue_addr;
    logic                  issue_ready;

    reg_addr_t             rs_addr;
    reg_addr_t             rt_addr;
    logic                  rs_busy;
    logic                  rt_busy;

    logic                  stall_pipe;
    logic                  rf_wr_en;
    reg_addr_t             rf_wr_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;
    logic [NUM_REGS-1:0]   busy_vec;

    modport master (
        output wb_en, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        output issue_valid, issue_addr,
        input  issue_ready,
        output rs_addr, rt_addr,
        input  rs_busy, rt_busy,
        input  stall_pipe, rf_wr_en, rf_wr_addr, rf_wr_data, busy_vec
    );

    modport slave (
        input  wb_en, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        input  issue_valid, issue_addr,
        output issue_ready,
        input  rs_addr, rt_addr,
        output rs_busy, rt_busy,
        output stall_pipe, rf_wr_en, rf_wr_addr, rf_wr_data, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-MDU-write scoreboard; set and clear land on the next posedge, set wins.
// Queries and issue_ready read registered state only; register 0 is never busy.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           rs_addr,
    input  reg_addr_t           rt_addr,
    input  reg_addr_t           issue_addr,
    output logic                rs_busy,
    output logic                rt_busy,
    output logic                issue_ready,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt = busy_nxt & ~reg_onehot(clr_addr);
        end
        // Applied after the clear so a same-cycle reissue keeps the register busy.
        if (set_en) begin
            busy_nxt = busy_nxt | reg_onehot(set_addr);
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs_busy     = busy[rs_addr];
    assign rt_busy     = busy[rt_addr];
    assign issue_ready = !busy[issue_addr] || (issue_addr == ZERO_REG);
    assign busy_vec    = busy;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single RF write port between WB and the MDU; WB wins unless the MDU has waited STARVE_LIMIT cycles.
// Zero-cycle grant latency; starvation forces a one-cycle stall_pipe during which WB must be re-presented.
module rf_wr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst_n,
    rf_wr_arbiter_if.slave bus
);

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      wait_cnt;
    logic                  stall;
    logic                  wb_claim;
    logic                  mdu_sel;
    logic                  mdu_ready;
    logic                  mdu_hs;
    logic                  sb_issue_ready;
    logic                  issue_ready;
    logic                  issue_set;
    logic                  wr_en;
    reg_addr_t             wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign stall     = (wait_cnt == LIMIT);
    assign wb_claim  = bus.wb_en && (bus.wb_addr != ZERO_REG);
    assign mdu_sel   = stall || !wb_claim;
    assign mdu_ready = rst_n && mdu_sel;
    assign mdu_hs    = bus.mdu_valid && mdu_ready;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.wb_addr;
        wr_data = bus.wb_data;
        if (mdu_sel) begin
            if (mdu_hs) begin
                wr_en   = (bus.mdu_addr != ZERO_REG);
                wr_addr = bus.mdu_addr;
                wr_data = bus.mdu_data;
            end
        end else begin
            wr_en = 1'b1;
        end
        if (!rst_n) begin
            wr_en   = 1'b0;
            wr_addr = ZERO_REG;
            wr_data = '0;
        end
    end

    // Counts only while a result sits unaccepted; saturation is what raises stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!bus.mdu_valid || mdu_hs) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign issue_ready = rst_n && sb_issue_ready;
    assign issue_set   = bus.issue_valid && issue_ready && (bus.issue_addr != ZERO_REG);

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (issue_set),
        .set_addr    (bus.issue_addr),
        .clr_en      (mdu_hs),
        .clr_addr    (bus.mdu_addr),
        .rs_addr     (bus.rs_addr),
        .rt_addr     (bus.rt_addr),
        .issue_addr  (bus.issue_addr),
        .rs_busy     (bus.rs_busy),
        .rt_busy     (bus.rt_busy),
        .issue_ready (sb_issue_ready),
        .busy_vec    (bus.busy_vec)
    );

    assign bus.mdu_ready   = mdu_ready;
    assign bus.issue_ready = issue_ready;
    assign bus.stall_pipe  = stall;
    assign bus.rf_wr_en    = wr_en;
    assign bus.rf_wr_addr  = wr_addr;
    assign bus.rf_wr_data  = wr_data;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected RF writes are queued as stimulus is driven and popped each cycle.
module tb_rf_wr_arbiter;
    import rf_ctrl_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    wr_t  exp_q[$];
    logic [31:0] exp_busy;

    rf_wr_arbiter_if #(.DATA_WIDTH(32)) bus ();

    rf_wr_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One RF write expected per queued entry in this cycle; none otherwise.
    task automatic observe(input string tag);
        wr_t e;
        chk({tag, "_wr_en"}, 32'(bus.rf_wr_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (bus.rf_wr_en) begin
                chk({tag, "_wr_addr"}, 32'(bus.rf_wr_addr), 32'(e.addr));
                chk({tag, "_wr_data"}, bus.rf_wr_data, e.data);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_busy = '0;
        rst_n = 1'b0;
        bus.wb_en = 1'b0;       bus.wb_addr = '0;    bus.wb_data = '0;
        bus.mdu_valid = 1'b0;   bus.mdu_addr = '0;   bus.mdu_data = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;
        bus.rs_addr = '0;       bus.rt_addr = '0;

        // Reset state
        #3;
        chk("rst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        chk("rst_stall", 32'(bus.stall_pipe), 32'd0);
        chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst_busy_vec", bus.busy_vec, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Issue reg 5, then the MDU returns it with WB idle
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd5;
        #2 chk("iss5_ready", 32'(bus.issue_ready), 32'd1);
        cyc();
        exp_busy[5] = 1'b1;
        bus.issue_valid = 1'b0;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd5; bus.mdu_data = 32'hDEAD;
        expect_wr(5'd5, 32'hDEAD);
        #2;
        chk("mdu5_ready", 32'(bus.mdu_ready), 32'd1);
        chk("mdu5_busy_during", bus.busy_vec, exp_busy);
        observe("mdu5");
        cyc();
        exp_busy[5] = 1'b0;
        bus.mdu_valid = 1'b0;
        #2;
        chk("mdu5_busy_after", bus.busy_vec, exp_busy);
        observe("idle");
        cyc();

        // WB held continuously while the MDU waits for reg 7
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0000_0333;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'h0000_7777;
        for (int i = 0; i < 4; i++) begin
            expect_wr(5'd3, 32'h0000_0333);
            #2;
            chk($sformatf("starve_c%0d_ready", i), 32'(bus.mdu_ready), 32'd0);
            chk($sformatf("starve_c%0d_stall", i), 32'(bus.stall_pipe), 32'd0);
            observe($sformatf("starve_c%0d", i));
            cyc();
        end
        expect_wr(5'd7, 32'h0000_7777);
        #2;
        chk("starve_c4_stall", 32'(bus.stall_pipe), 32'd1);
        chk("starve_c4_ready", 32'(bus.mdu_ready), 32'd1);
        observe("starve_c4");
        cyc();
        bus.mdu_valid = 1'b0;
        expect_wr(5'd3, 32'h0000_0333);
        #2;
        chk("starve_c5_stall", 32'(bus.stall_pipe), 32'd0);
        observe("starve_c5");
        cyc();
        bus.wb_en = 1'b0;

        // Double issue to reg 9
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
        #2 chk("iss9a_ready", 32'(bus.issue_ready), 32'd1);
        cyc();
        exp_busy[9] = 1'b1;
        bus.rs_addr = 5'd9; bus.rt_addr = 5'd3;
        #2;
        chk("iss9b_ready", 32'(bus.issue_ready), 32'd0);
        chk("rs9_busy", 32'(bus.rs_busy), 32'd1);
        chk("rt3_busy", 32'(bus.rt_busy), 32'd0);
        chk("iss9_busy_vec", bus.busy_vec, exp_busy);
        cyc();

        // Same-cycle MDU completion and issue to reg 4: set wins
        bus.issue_addr = 5'd4;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd4; bus.mdu_data = 32'h0000_0044;
        expect_wr(5'd4, 32'h0000_0044);
        #2;
        chk("iss4_ready", 32'(bus.issue_ready), 32'd1);
        observe("mdu4_set");
        cyc();
        exp_busy[4] = 1'b1;
        bus.mdu_valid = 1'b0;
        bus.issue_addr = 5'd0; bus.rt_addr = 5'd4;
        #2;
        chk("setwins_busy_vec", bus.busy_vec, exp_busy);
        chk("rt4_busy", 32'(bus.rt_busy), 32'd1);
        chk("iss0_ready", 32'(bus.issue_ready), 32'd1);
        cyc();
        bus.issue_valid = 1'b0;
        #2 chk("iss0_busy_vec", bus.busy_vec, exp_busy);

        // WB to $0 does not block the MDU
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hBAD0;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd4; bus.mdu_data = 32'h0000_4444;
        expect_wr(5'd4, 32'h0000_4444);
        #2;
        chk("wb0_mdu_ready", 32'(bus.mdu_ready), 32'd1);
        observe("wb0_mdu4");
        cyc();
        exp_busy[4] = 1'b0;
        // MDU result for $0 handshakes but writes nothing
        bus.wb_en = 1'b0;
        bus.mdu_addr = 5'd0; bus.mdu_data = 32'h0000_0055;
        #2;
        chk("mdu0_ready", 32'(bus.mdu_ready), 32'd1);
        chk("mdu4_clr_busy_vec", bus.busy_vec, exp_busy);
        observe("mdu0");
        cyc();
        bus.mdu_valid = 1'b0;

        // Build busy{5,9} and wait_cnt=2, then reset asynchronously
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd5;
        cyc();
        exp_busy[5] = 1'b1;
        bus.issue_valid = 1'b0;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0000_0333;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'h0000_7777;
        for (int i = 0; i < 2; i++) begin
            expect_wr(5'd3, 32'h0000_0333);
            #2 observe($sformatf("prerst_c%0d", i));
            cyc();
        end
        #1;
        chk("prerst_busy_vec", bus.busy_vec, exp_busy);
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd12;
        bus.rs_addr = 5'd9; bus.rt_addr = 5'd5;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
        chk("arst_issue_ready", 32'(bus.issue_ready), 32'd0);
        chk("arst_stall", 32'(bus.stall_pipe), 32'd0);
        chk("arst_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("arst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
        chk("arst_wr_data", bus.rf_wr_data, 32'd0);
        chk("arst_rs_busy", 32'(bus.rs_busy), 32'd0);
        chk("arst_rt_busy", 32'(bus.rt_busy), 32'd0);
        chk("arst_busy_vec", bus.busy_vec, 32'd0);
        exp_busy = '0;
        bus.issue_valid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // wait_cnt restarted from 0: stall reappears only on the fifth cycle
        for (int i = 0; i < 4; i++) begin
            expect_wr(5'd3, 32'h0000_0333);
            #2;
            chk($sformatf("post_c%0d_stall", i), 32'(bus.stall_pipe), 32'd0);
            chk($sformatf("post_c%0d_busy_vec", i), bus.busy_vec, exp_busy);
            observe($sformatf("post_c%0d", i));
            cyc();
        end
        expect_wr(5'd7, 32'h0000_7777);
        #2;
        chk("post_c4_stall", 32'(bus.stall_pipe), 32'd1);
        observe("post_c4");
        cyc();
        bus.wb_en = 1'b0;
        bus.mdu_valid = 1'b0;
        #2;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_wr_en", 32'(bus.rf_wr_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
